// File: rtl/cart_sram_pkg.sv
// Shared types and helpers for the cartridge SRAM arbiter: FSM state encoding,
// byte-lane helpers and default wait-state constants.
package cart_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_WRITE   = 2'd2,
      ST_RECOVER = 2'd3
   } arb_state_t;

   localparam int DEF_READ_WAIT  = 2;
   localparam int DEF_WRITE_WAIT = 2;
   localparam int DEF_CPU_BURST  = 8;
   localparam int TIMER_W        = 8;

   // Returns {ub, lb}; byte address bit 0 set selects the upper lane
   function automatic logic [1:0] lane_sel(input logic byte_sel);
      lane_sel = byte_sel ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [7:0] lane_pick(input logic [15:0] word, input logic upper);
      lane_pick = upper ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
// Shared by the read and write phases of the SRAM arbiter.
module sram_wait_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_r;

   // Load on request, otherwise count down and rest at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != '0) begin
         cnt_r <= cnt_r - W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == '0);

endmodule

// File: rtl/cart_sram_arbiter.sv
// Shares one 16-bit SRAM between the MBC read path and the UART byte loader.
// Define CART_ARB_STARVE_GUARD_EN to force a loader grant after CPU_BURST CPU grants.
module cart_sram_arbiter
   import cart_sram_pkg::*;
#(
   parameter int ADDR_W     = 19,
   parameter int READ_WAIT  = DEF_READ_WAIT,
   parameter int WRITE_WAIT = DEF_WRITE_WAIT,
   parameter int CPU_BURST  = DEF_CPU_BURST
) (
   input  logic              clockgb,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_valid,
   input  logic              prog_start,
   input  logic              prog_valid,
   input  logic [7:0]        prog_data,
   output logic              prog_ready,
   output logic [ADDR_W-1:0] prog_count,
   output logic              prog_full,
   output logic [ADDR_W-2:0] sram_addr,
   output logic [15:0]       sram_wdata,
   input  logic [15:0]       sram_rdata,
   output logic              sram_oe,
   output logic              sram_we,
   output logic              sram_ub,
   output logic              sram_lb
);

`ifdef CART_ARB_STARVE_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif
   localparam int BURST_W = $clog2(CPU_BURST + 32'sd1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CPU_BURST);

   arb_state_t state_r, state_s;
   logic [ADDR_W-2:0] sram_addr_r, addr_s;
   logic [15:0]       sram_wdata_r, wdata_s;
   logic              sram_oe_r, oe_s, sram_we_r, we_s;
   logic              sram_ub_r, sram_lb_r;
   logic [1:0]        lanes_s;
   logic [7:0]        cpu_rdata_r, rdata_s;
   logic              cpu_valid_r, valid_s;
   logic [ADDR_W-1:0] ptr_r;
   logic              full_r, start_pend_r;
   logic [BURST_W-1:0] burst_r;
   logic              load_s, done_s;
   logic [TIMER_W-1:0] load_val_s;
   logic              accept_s, cpu_grant_s, wr_done_s, prog_ok_s, prog_turn_s;

   sram_wait_timer #(.W(TIMER_W)) u_timer (
      .clk      (clockgb),
      .rst_n    (resetn),
      .load     (load_s),
      .load_val (load_val_s),
      .done     (done_s)
   );

   assign prog_ok_s   = prog_valid && !full_r && !prog_start;
   assign prog_turn_s = GUARD_EN && (burst_r == BURST_MAX) && prog_ok_s;

   // Arbitration, strobe sequencing and read-data capture
   always_comb begin
      state_s     = state_r;
      addr_s      = sram_addr_r;
      wdata_s     = sram_wdata_r;
      lanes_s     = {sram_ub_r, sram_lb_r};
      oe_s        = 1'b0;
      we_s        = 1'b0;
      rdata_s     = cpu_rdata_r;
      valid_s     = 1'b0;
      load_s      = 1'b0;
      load_val_s  = '0;
      accept_s    = 1'b0;
      cpu_grant_s = 1'b0;
      wr_done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            lanes_s = 2'b00;
            if (cpu_valid_r) begin
               // The request just served is still high this cycle; never re-grant it
               state_s = ST_IDLE;
            end else if (prog_turn_s || (prog_ok_s && !cpu_req)) begin
               accept_s   = 1'b1;
               state_s    = ST_WRITE;
               addr_s     = ptr_r[ADDR_W-1:1];
               lanes_s    = lane_sel(ptr_r[0]);
               wdata_s    = {prog_data, prog_data};
               load_s     = 1'b1;
               load_val_s = TIMER_W'(WRITE_WAIT);
            end else if (cpu_req) begin
               cpu_grant_s = 1'b1;
               state_s     = ST_READ;
               addr_s      = cpu_addr[ADDR_W-1:1];
               lanes_s     = lane_sel(cpu_addr[0]);
               oe_s        = 1'b1;
               load_s      = 1'b1;
               load_val_s  = TIMER_W'(READ_WAIT - 32'sd1);
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (done_s) begin
               state_s = ST_IDLE;
               rdata_s = lane_pick(sram_rdata, sram_ub_r);
               valid_s = 1'b1;
               lanes_s = 2'b00;
            end else begin
               oe_s = 1'b1;
            end
         end
         ST_WRITE: begin
            // First WRITE cycle is address/data setup; WE follows for WRITE_WAIT cycles
            if (done_s) begin
               state_s = ST_RECOVER;
               lanes_s = 2'b00;
            end else begin
               we_s = 1'b1;
            end
         end
         ST_RECOVER: begin
            state_s   = ST_IDLE;
            wr_done_s = 1'b1;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and registered SRAM/CPU outputs
   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         state_r      <= ST_IDLE;
         sram_addr_r  <= '0;
         sram_wdata_r <= '0;
         sram_oe_r    <= 1'b0;
         sram_we_r    <= 1'b0;
         sram_ub_r    <= 1'b0;
         sram_lb_r    <= 1'b0;
         cpu_rdata_r  <= '0;
         cpu_valid_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         sram_addr_r  <= addr_s;
         sram_wdata_r <= wdata_s;
         sram_oe_r    <= oe_s;
         sram_we_r    <= we_s;
         sram_ub_r    <= lanes_s[1];
         sram_lb_r    <= lanes_s[0];
         cpu_rdata_r  <= rdata_s;
         cpu_valid_r  <= valid_s;
      end
   end

   // Loader write pointer; a start seen mid-write is applied once the write retires
   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         ptr_r        <= '0;
         full_r       <= 1'b0;
         start_pend_r <= 1'b0;
      end else if (wr_done_s) begin
         start_pend_r <= 1'b0;
         if (prog_start || start_pend_r) begin
            ptr_r  <= '0;
            full_r <= 1'b0;
         end else if (ptr_r == '1) begin
            full_r <= 1'b1;
         end else begin
            ptr_r <= ptr_r + ADDR_W'(1'b1);
         end
      end else if (prog_start) begin
         if ((state_r == ST_WRITE) || (state_r == ST_RECOVER)) begin
            start_pend_r <= 1'b1;
         end else begin
            ptr_r  <= '0;
            full_r <= 1'b0;
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Consecutive CPU grants taken while the loader had a byte waiting
   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         burst_r <= '0;
      end else if (accept_s) begin
         burst_r <= '0;
      end else if (cpu_grant_s) begin
         if (!prog_valid) begin
            burst_r <= '0;
         end else if (burst_r != BURST_MAX) begin
            burst_r <= burst_r + BURST_W'(1'b1);
         end else begin
            burst_r <= burst_r;
         end
      end else begin
         burst_r <= burst_r;
      end
   end

   assign prog_ready = accept_s;
   assign prog_count = ptr_r;
   assign prog_full  = full_r;
   assign sram_addr  = sram_addr_r;
   assign sram_wdata = sram_wdata_r;
   assign sram_oe    = sram_oe_r;
   assign sram_we    = sram_we_r;
   assign sram_ub    = sram_ub_r;
   assign sram_lb    = sram_lb_r;
   assign cpu_rdata  = cpu_rdata_r;
   assign cpu_valid  = cpu_valid_r;

endmodule
